// File: rtl/clint_timer.sv
// clint_timer: core-local timer / interrupt block on an APB-style bus.
//
// Holds a 64-bit free-running mtime advanced by a programmable prescaler,
// one 64-bit mtimecmp and one msip bit per hart, and drives per-hart timer
// and software interrupt lines.
//
// Ports:
//   pclk             clock, all logic on rising edge
//   reset            synchronous active-high reset
//   paddr/pdata      bus address / write data
//   pstb             byte write strobes (pstb[i] enables pdata[8i+7:8i])
//   psel/penable     setup (psel=1,penable=0) and access (psel=1,penable=1)
//   pwrite           1 = write, 0 = read
//   prdata           registered read data, valid while pready=1, else 0
//   pready           one-cycle transfer completion
//   perr             error response (bad address), valid with pready
//   timer_interrupt  per-hart, registered (mtime >= mtimecmp[h])
//   soft_interrupt   per-hart, msip[h]
//
// Handshake: an access cycle seen while pready=0 completes on the following
// edge; that edge raises pready for exactly one cycle together with perr and
// prdata, and commits any write. The next edge returns pready, perr and
// prdata to 0. Because pready=1 blocks a new completion, a psel/penable held
// through the pready cycle does not start a second transfer.
module clint_timer #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_HARTS      = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h11000000,
  parameter logic [31:0]           PRESCALE_RESET = 32'd1000
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pdata,
  output logic [DATA_WIDTH-1:0] prdata,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [3:0]            pstb,
  output logic                  pready,
  output logic                  perr,
  output logic [NUM_HARTS-1:0]  timer_interrupt,
  output logic [NUM_HARTS-1:0]  soft_interrupt
);

  localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  localparam logic [15:0] MSIP_END = 16'(4 * NUM_HARTS);
  localparam logic [15:0] CMP_BASE = 16'h4000;
  localparam logic [15:0] CMP_END  = 16'(16'h4000 + 8 * NUM_HARTS);
  localparam logic [15:0] PRE_OFF  = 16'hBF00;
  localparam logic [15:0] MLO_OFF  = 16'hBFF8;
  localparam logic [15:0] MHI_OFF  = 16'hBFFC;

  // Registered state
  logic [63:0]           mtime_q, mtime_d;
  logic [31:0]           pcnt_q, pcnt_d;
  logic [31:0]           prescale_q, prescale_d;
  logic [63:0]           cmp_q [NUM_HARTS];
  logic [63:0]           cmp_d [NUM_HARTS];
  logic [NUM_HARTS-1:0]  msip_q, msip_d;
  logic [NUM_HARTS-1:0]  ti_q, ti_d;
  logic                  pready_q, pready_d;
  logic                  perr_q, perr_d;
  logic [31:0]           prdata_q, prdata_d;

  // Decode
  logic [ADDR_WIDTH-1:0] off;
  logic [15:0]           off16;
  logic                  in_win;
  logic                  aligned;
  logic                  sel_msip, sel_cmp, sel_pre, sel_mlo, sel_mhi;
  logic                  addr_ok;
  logic [HW-1:0]         msip_idx;
  logic [HW-1:0]         cmp_idx;
  logic                  cmp_hi;
  logic [15:0]           cmp_rel;

  // Control
  logic                  xfer;
  logic                  wr_any;
  logic                  tick;
  logic [31:0]           rdata;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  stb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (stb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    off      = paddr - BASE_ADDR;
    off16    = off[15:0];
    in_win   = ((off >> 16) == '0);
    aligned  = (off16[1:0] == 2'b00);
    cmp_rel  = off16 - CMP_BASE;
    msip_idx = off16[2 +: HW];
    cmp_idx  = cmp_rel[3 +: HW];
    cmp_hi   = off16[2];
    sel_msip = in_win && aligned && (off16 < MSIP_END);
    sel_cmp  = in_win && aligned && (off16 >= CMP_BASE) && (off16 < CMP_END);
    sel_pre  = in_win && (off16 == PRE_OFF);
    sel_mlo  = in_win && (off16 == MLO_OFF);
    sel_mhi  = in_win && (off16 == MHI_OFF);
    addr_ok  = sel_msip | sel_cmp | sel_pre | sel_mlo | sel_mhi;
  end

  // A completing transfer is an access cycle not already being answered.
  assign xfer = psel & penable & ~pready_q;
  // A zero-strobe write completes normally but changes nothing, including
  // the tick/prescaler side effects below.
  assign wr_any = xfer & pwrite & addr_ok & (|pstb);
  assign tick = (pcnt_q == prescale_q);

  // Read mux sees pre-edge state, so a tick on the completing edge is not
  // visible in the returned value.
  always_comb begin
    rdata = '0;
    if (sel_msip) begin
      rdata = {31'd0, msip_q[msip_idx]};
    end else if (sel_cmp) begin
      rdata = cmp_hi ? cmp_q[cmp_idx][63:32] : cmp_q[cmp_idx][31:0];
    end else if (sel_pre) begin
      rdata = prescale_q;
    end else if (sel_mlo) begin
      rdata = mtime_q[31:0];
    end else if (sel_mhi) begin
      rdata = mtime_q[63:32];
    end
  end

  always_comb begin
    // Prescaler
    pcnt_d     = tick ? 32'd0 : pcnt_q + 32'd1;
    prescale_d = prescale_q;
    if (wr_any && sel_pre) begin
      prescale_d = merge(prescale_q, pdata, pstb);
      pcnt_d     = 32'd0;
    end

    // mtime: a bus write to either half replaces the tick for this cycle,
    // and no carry crosses between halves.
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_any && sel_mlo) begin
      mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], pdata, pstb)};
    end else if (wr_any && sel_mhi) begin
      mtime_d = {merge(mtime_q[63:32], pdata, pstb), mtime_q[31:0]};
    end

    // Compare registers
    for (int h = 0; h < NUM_HARTS; h++) begin
      cmp_d[h] = cmp_q[h];
    end
    if (wr_any && sel_cmp) begin
      if (cmp_hi) begin
        cmp_d[cmp_idx][63:32] = merge(cmp_q[cmp_idx][63:32], pdata, pstb);
      end else begin
        cmp_d[cmp_idx][31:0] = merge(cmp_q[cmp_idx][31:0], pdata, pstb);
      end
    end

    // Software interrupt bits: only byte 0 bit 0 is stored.
    msip_d = msip_q;
    if (wr_any && sel_msip && pstb[0]) begin
      msip_d[msip_idx] = pdata[0];
    end

    // Timer interrupt compares the current registers every cycle.
    for (int h = 0; h < NUM_HARTS; h++) begin
      ti_d[h] = (mtime_q >= cmp_q[h]);
    end

    // Bus response
    pready_d = xfer;
    perr_d   = xfer & ~addr_ok;
    prdata_d = (xfer && !pwrite) ? rdata : 32'd0;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      mtime_q    <= '0;
      pcnt_q     <= '0;
      prescale_q <= PRESCALE_RESET;
      for (int h = 0; h < NUM_HARTS; h++) begin
        cmp_q[h] <= '1;
      end
      msip_q     <= '0;
      ti_q       <= '0;
      pready_q   <= 1'b0;
      perr_q     <= 1'b0;
      prdata_q   <= '0;
    end else begin
      mtime_q    <= mtime_d;
      pcnt_q     <= pcnt_d;
      prescale_q <= prescale_d;
      for (int h = 0; h < NUM_HARTS; h++) begin
        cmp_q[h] <= cmp_d[h];
      end
      msip_q     <= msip_d;
      ti_q       <= ti_d;
      pready_q   <= pready_d;
      perr_q     <= perr_d;
      prdata_q   <= prdata_d;
    end
  end

  assign prdata          = prdata_q;
  assign pready          = pready_q;
  assign perr            = perr_q;
  assign timer_interrupt = ti_q;
  assign soft_interrupt  = msip_q;

endmodule
